// File: rtl/ysyx_22050368_ifu_pkg.sv
// Shared constants for the decoupled instruction-fetch unit.
package ysyx_22050368_ifu_pkg;
  localparam int unsigned IFU_ADDR_W   = 64;
  localparam int unsigned IFU_ILEN     = 32;
  localparam int unsigned IFU_DEPTH    = 4;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int unsigned PC_INC       = 4;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ysyx_22050368_ififo.sv
// Synchronous FIFO holding {pc, inst} records; power-of-2 depth, pointer rollover wrap.
module ysyx_22050368_ififo
  import ysyx_22050368_ifu_pkg::*;
#(
  parameter int unsigned DEPTH = IFU_DEPTH,
  parameter int unsigned WIDTH = IFU_ADDR_W + IFU_ILEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic [WIDTH-1:0]               head_o
);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && count_q == CW'(DEPTH)));
endmodule

// File: rtl/ysyx_22050368_ifu.sv
// Instruction-fetch unit: own PC, credit-limited in-order fetches, flush with stale-response drop.
module ysyx_22050368_ifu
  import ysyx_22050368_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter int unsigned       ILEN     = IFU_ILEN,
  parameter int unsigned       DEPTH    = IFU_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [ILEN-1:0]   imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ILEN-1:0]   inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              busy_o
);
  localparam int unsigned       CW      = cnt_width(DEPTH);
  localparam int unsigned       FW      = ADDR_W + ILEN;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
  localparam logic [CW:0]       CREDITS = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              req_pend_q, req_pend_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_head;
  logic [CW:0]       credit_used;
  logic              start_c, req_fire, rsp_ok, push, pop;
  logic [ADDR_W-1:0] jump_pc;
  logic              unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr_i[1:0];
  assign jump_pc          = {jump_addr_i[ADDR_W-1:2], 2'b00};

  // Credits use registered occupancy only, so a same-cycle pop frees nothing.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign start_c     = !rst && !jump_flag_i && !hold_i && (credit_used < CREDITS);

  assign imem_req_valid_o = !rst && !jump_flag_i && (req_pend_q || start_c);
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign rsp_ok = imem_rsp_valid_i && (outstanding_q != '0);
  assign push   = rsp_ok && (drop_q == '0) && !jump_flag_i;

  assign inst_valid_o = !rst && (fifo_count != '0) && !jump_flag_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = fifo_head[ILEN-1:0];
  assign inst_addr_o  = fifo_head[FW-1:ILEN];
  assign busy_o       = !rst && (outstanding_q != '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    req_pend_d    = req_pend_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    if (jump_flag_i) begin
      fetch_pc_d = jump_pc;
      rsp_pc_d   = jump_pc;
      req_pend_d = 1'b0;
      drop_d     = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pend_d = 1'b0;
      end else if (imem_req_valid_o) begin
        req_pend_d = 1'b1;
      end
      if (rsp_ok) begin
        if (drop_q != '0) drop_d   = drop_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      req_pend_q    <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      req_pend_q    <= req_pend_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  ysyx_22050368_ififo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jump_flag_i),
    .data_i  ({rsp_pc_q, imem_rsp_data_i}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid_i && outstanding_q == '0));
endmodule
